// File: rtl/kp_emu_pkg.sv
// Shared definitions for the keypad matrix emulator.
//   kp_state_t    : press-sequence state encoding
//   KEY_* ranges  : row/column index fields inside the 4-bit key code
//   LFSR_TAPS     : Galois feedback mask for x^8+x^6+x^5+x^4+1
package kp_emu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HELD,
    BOUNCE_OUT,
    DONE
  } kp_state_t;

  localparam int unsigned KEY_ROW_MSB = 3;
  localparam int unsigned KEY_ROW_LSB = 2;
  localparam int unsigned KEY_COL_MSB = 1;
  localparam int unsigned KEY_COL_LSB = 0;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/kp_lfsr8.sv
// 8-bit right-shifting Galois LFSR used as the contact-chatter source.
//   clk  : clock
//   rst  : async active-high reset, loads SEED
//   en   : advance one step this cycle
//   out  : current LSB, used as the raw contact level
module kp_lfsr8
  import kp_emu_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic out
);

  logic [7:0] state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {1'b0, state[7:1]} ^ (state[0] ? LFSR_TAPS : 8'h00);
    end
  end

  assign out = state[0];

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Key-side model of a 4x4 scanned keypad: presses one requested key with
// contact bounce on make and break, holds it for a programmed time, then
// releases it.
//   clk, rst   : clock, async active-high reset
//   row        : row strobes from the scanner (active-high)
//   col        : column returns (active-high), combinational from row
//   req_valid / req_ready / req_key / req_hold : press request handshake
//   abort      : early release during bounce-in or hold
//   busy       : sequence in progress
//   done       : one-cycle completion pulse
module keypad_matrix_emulator
  import kp_emu_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_W        = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_key,
  input  logic [HOLD_W-1:0] req_hold,
  input  logic              abort,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BW        = (BOUNCE_CYCLES < 2) ? 1 : $clog2(BOUNCE_CYCLES + 1);
  localparam logic [BW-1:0] BCNT_LOAD = BW'(BOUNCE_CYCLES);
  localparam bit          NO_BOUNCE = (BOUNCE_CYCLES == 0);

  kp_state_t         state_q, state_d;
  logic [3:0]        key_q;
  logic [HOLD_W-1:0] hold_q, hcnt_q, hcnt_d, hold_eff;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              contact, lfsr_en, lfsr_bit, accept;

  kp_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .out (lfsr_bit)
  );

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign hold_eff  = (req_hold == '0) ? HOLD_W'(1) : req_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      if (accept) begin
        key_q  <= req_key;
        hold_q <= hold_eff;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    contact = 1'b0;
    lfsr_en = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          if (NO_BOUNCE) begin
            state_d = HELD;
            hcnt_d  = hold_eff;
          end else begin
            state_d = BOUNCE_IN;
            bcnt_d  = BCNT_LOAD;
          end
        end
      end
      BOUNCE_IN: begin
        lfsr_en = 1'b1;
        contact = (bcnt_q == BW'(1)) ? 1'b1 : lfsr_bit;
        if (abort) begin
          state_d = BOUNCE_OUT;
          bcnt_d  = BCNT_LOAD;
        end else if (bcnt_q == BW'(1)) begin
          state_d = HELD;
          hcnt_d  = hold_q;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      HELD: begin
        contact = 1'b1;
        if (abort || hcnt_q == HOLD_W'(1)) begin
          if (NO_BOUNCE) begin
            state_d = DONE;
          end else begin
            state_d = BOUNCE_OUT;
            bcnt_d  = BCNT_LOAD;
          end
        end else begin
          hcnt_d = hcnt_q - HOLD_W'(1);
        end
      end
      BOUNCE_OUT: begin
        lfsr_en = 1'b1;
        contact = (bcnt_q == BW'(1)) ? 1'b0 : lfsr_bit;
        if (bcnt_q == BW'(1)) begin
          state_d = DONE;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Only the captured key's column can answer, and only while its row is strobed.
  always_comb begin
    col = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      col[k] = contact && row[key_q[KEY_ROW_MSB:KEY_ROW_LSB]]
               && (key_q[KEY_COL_MSB:KEY_COL_LSB] == 2'(k));
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
module tb_keypad_matrix_emulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: no bounce
  logic [3:0]  row_a = '0, col_a, key_a = '0;
  logic        valid_a = 1'b0, ready_a, abort_a = 1'b0, busy_a, done_a;
  logic [15:0] hold_a = '0;

  // Instance B: 16 cycles of bounce
  logic [3:0]  row_b = '0, col_b, key_b = '0;
  logic        valid_b = 1'b0, ready_b, abort_b = 1'b0, busy_b, done_b;
  logic [15:0] hold_b = '0;

  logic [7:0]  lfsr_m = 8'hA5;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  keypad_matrix_emulator #(.BOUNCE_CYCLES(0), .HOLD_W(16), .LFSR_SEED(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .row(row_a), .col(col_a),
    .req_valid(valid_a), .req_ready(ready_a), .req_key(key_a), .req_hold(hold_a),
    .abort(abort_a), .busy(busy_a), .done(done_a)
  );

  keypad_matrix_emulator #(.BOUNCE_CYCLES(16), .HOLD_W(16), .LFSR_SEED(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .row(row_b), .col(col_b),
    .req_valid(valid_b), .req_ready(ready_b), .req_key(key_b), .req_hold(hold_b),
    .abort(abort_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  // Presses on instance A; returns #1 after the accept edge (start of cycle T+1).
  task automatic press_a(input logic [3:0] k, input logic [15:0] h, input logic with_abort);
    int unsigned n = 0;
    while (ready_a !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL press_a_ready: req_ready=%b required 1", ready_a);
    end
    valid_a = 1'b1; key_a = k; hold_a = h; abort_a = with_abort;
    @(posedge clk); #1;
    valid_a = 1'b0; abort_a = 1'b0;
  endtask

  task automatic press_b(input logic [3:0] k, input logic [15:0] h);
    int unsigned n = 0;
    while (ready_b !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL press_b_ready: req_ready=%b required 1", ready_b);
    end
    valid_b = 1'b1; key_b = k; hold_b = h;
    @(posedge clk); #1;
    valid_b = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({col_a, busy_a, done_a, ready_a} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_a: col/busy/done/ready=%b required 0000000", {col_a, busy_a, done_a, ready_a});
    end
    n_checks++;
    if ({col_b, busy_b, done_b, ready_b} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_b: col/busy/done/ready=%b required 0000000", {col_b, busy_b, done_b, ready_b});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: ready_a=%b ready_b=%b required 1 1", ready_a, ready_b);
    end
  endtask

  task automatic test_hold_nobounce;
    row_a = 4'b0010;
    press_a(4'h6, 16'd10, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (col_a !== ((i <= 10) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL hold_col c%0d: col=%b required %b", i, col_a, (i <= 10) ? 4'b0100 : 4'b0000);
      end
      n_checks++;
      if ({busy_a, done_a, ready_a} !== {1'(i <= 11), 1'(i == 11), 1'(i == 12)}) begin
        n_fail++;
        $display("FAIL hold_ctl c%0d: busy/done/ready=%b required %b", i, {busy_a, done_a, ready_a},
                 {1'(i <= 11), 1'(i == 11), 1'(i == 12)});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_row_scan;
    logic [3:0] exp_col;
    press_a(4'h6, 16'd10, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      row_a = (i == 9) ? 4'b1111 : (4'b0001 << ((i - 1) % 4));
      exp_col = row_a[1] ? 4'b0100 : 4'b0000;
      @(negedge clk);
      n_checks++;
      if (col_a !== exp_col) begin
        n_fail++;
        $display("FAIL row_scan c%0d row=%b: col=%b required %b", i, row_a, col_a, exp_col);
      end
      @(posedge clk); #1;
    end
    row_a = 4'b0010;
  endtask

  // One bounced press on instance B checked against the LFSR model.
  // abort_at=0 means no abort; otherwise abort is driven during that cycle of bounce-in.
  task automatic bounce_seq(input logic [15:0] h, input int unsigned abort_at, output logic [14:0] obs);
    int unsigned in_end, held_end, out_end;
    logic c;
    in_end   = (abort_at != 0) ? abort_at : 16;
    held_end = (abort_at != 0) ? abort_at : 16 + int'(h);
    out_end  = held_end + 16;
    obs = '0;
    row_b = 4'b1000;
    press_b(4'hF, h);
    for (int unsigned i = 1; i <= out_end + 2; i++) begin
      abort_b = (i == abort_at);
      key_b   = 4'h0;
      @(negedge clk);
      if (i <= in_end) begin
        c = (i == 16) ? 1'b1 : lfsr_m[0];
        if (i <= 15) obs[i-1] = col_b[3];
        lfsr_m = lfsr_step(lfsr_m);
      end else if (i <= held_end) begin
        c = 1'b1;
      end else if (i <= out_end) begin
        c = (i == out_end) ? 1'b0 : lfsr_m[0];
        lfsr_m = lfsr_step(lfsr_m);
      end else begin
        c = 1'b0;
      end
      n_checks++;
      if (col_b !== {c, 3'b000}) begin
        n_fail++;
        $display("FAIL bounce_col c%0d: col=%b required %b", i, col_b, {c, 3'b000});
      end
      n_checks++;
      if ({done_b, ready_b} !== {1'(i == out_end + 1), 1'(i == out_end + 2)}) begin
        n_fail++;
        $display("FAIL bounce_ctl c%0d: done/ready=%b required %b", i, {done_b, ready_b},
                 {1'(i == out_end + 1), 1'(i == out_end + 2)});
      end
      @(posedge clk); #1;
    end
    abort_b = 1'b0;
  endtask

  task automatic test_bounce;
    logic [14:0] obs1, obs2, obs3;
    bounce_seq(16'd5, 0, obs1);
    bounce_seq(16'd1, 0, obs2);
    n_checks++;
    if (obs1 === obs2) begin
      n_fail++;
      $display("FAIL bounce_reseed: second chatter=%h required to differ from first=%h", obs2, obs1);
    end
    bounce_seq(16'd5, 3, obs3);
  endtask

  task automatic test_abort;
    row_a = 4'b0010;
    // abort together with accept: accept wins
    press_a(4'h6, 16'd100, 1'b1);
    for (int i = 1; i <= 22; i++) begin
      abort_a = (i == 20);
      @(negedge clk);
      n_checks++;
      if (col_a !== ((i <= 20) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL abort_col c%0d: col=%b required %b", i, col_a, (i <= 20) ? 4'b0100 : 4'b0000);
      end
      n_checks++;
      if ({busy_a, done_a} !== {1'(i <= 21), 1'(i == 21)}) begin
        n_fail++;
        $display("FAIL abort_ctl c%0d: busy/done=%b required %b", i, {busy_a, done_a},
                 {1'(i <= 21), 1'(i == 21)});
      end
      @(posedge clk); #1;
    end
    abort_a = 1'b0;
  endtask

  task automatic test_back_to_back;
    int unsigned ph;
    int unsigned n = 0;
    row_a = 4'b0010;
    while (ready_a !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    valid_a = 1'b1; key_a = 4'h6; hold_a = 16'd0;
    @(posedge clk); #1;
    for (int i = 1; i <= 9; i++) begin
      ph = (i - 1) % 3;
      key_a = (ph == 0) ? 4'h0 : 4'h6;
      @(negedge clk);
      n_checks++;
      if ({col_a, done_a, ready_a} !== {((ph == 0) ? 4'b0100 : 4'b0000), 1'(ph == 1), 1'(ph == 2)}) begin
        n_fail++;
        $display("FAIL b2b c%0d: col/done/ready=%b required %b", i, {col_a, done_a, ready_a},
                 {((ph == 0) ? 4'b0100 : 4'b0000), 1'(ph == 1), 1'(ph == 2)});
      end
      @(posedge clk); #1;
    end
    valid_a = 1'b0;
    key_a   = 4'h6;
  endtask

  task automatic test_async_reset;
    row_a = 4'b0010;
    press_a(4'h6, 16'd50, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (col_a !== 4'b0100) begin
        n_fail++;
        $display("FAIL pre_reset_col c%0d: col=%b required 0100", i, col_a);
      end
      if (i < 7) begin
        @(posedge clk); #1;
      end
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({col_a, busy_a, done_a, ready_a} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset: col/busy/done/ready=%b required 0000000", {col_a, busy_a, done_a, ready_a});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({col_a, done_a, busy_a} !== 6'b0) begin
        n_fail++;
        $display("FAIL in_reset %0d: col/done/busy=%b required 000000", i, {col_a, done_a, busy_a});
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ready_a, busy_a, done_a, col_a} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL post_reset: ready/busy/done/col=%b required 1000000", {ready_a, busy_a, done_a, col_a});
    end
  endtask

  initial begin
    test_reset();
    test_hold_nobounce();
    test_row_scan();
    test_bounce();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
